// File: rtl/program_loader_if.sv
// Host byte stream plus program-memory write port of the program loader.
// The loader attaches through the slave modport; the host/memory side uses master.
interface program_loader_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream writer for program memory; holds the CPU in reset while loading.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module program_loader #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus,
  output logic            cpu_rst,
  output logic            done,
  output logic            error
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0]  HEADER = 8'hA5;
  localparam logic [16:0] CAP    = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  // State entered once the payload (or an empty frame) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t state_reg;
  state_t state_next;

  logic [15:0]           len_reg;
  logic [BCW-1:0]        byte_cnt_reg;
  logic [16:0]           word_idx_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [WORD_WIDTH-1:0] mem_wdata_reg;
  logic                  cpu_rst_reg;
  logic                  done_reg;
  logic                  error_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            cks_reg;
`endif

  logic                  accept;
  logic                  start_frame;
  logic                  write_word;
  logic                  word_last;
  logic                  frame_last;
  logic [15:0]           len_full;
  logic [WORD_WIDTH-1:0] word_shift;

  assign bus.in_ready  = ~rst & (state_reg != DONE);
  assign accept        = bus.in_valid & bus.in_ready;
  assign len_full      = {len_reg[15:8], bus.in_data};
  assign word_last     = (byte_cnt_reg == BCW'(BYTES - 1));
  assign frame_last    = word_last && (word_idx_reg == (17'(len_reg) - 17'd1));

  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign cpu_rst       = cpu_rst_reg;
  assign done          = done_reg;
  assign error         = error_reg;

  // word_shift is the word as it stands once the byte on in_data is appended.
  generate
    if (BYTES == 1) begin : g_single
      assign word_shift = bus.in_data;
    end else begin : g_multi
      logic [WORD_WIDTH-9:0] head_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          head_reg <= '0;
        end else if (accept && state_reg == DATA) begin
          head_reg <= word_shift[WORD_WIDTH-9:0];
        end
      end

      assign word_shift = {head_reg, bus.in_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    write_word  = 1'b0;
    case (state_reg)
      IDLE, ERR: begin
        if (accept && bus.in_data == HEADER) begin
          state_next  = LEN_HI;
          start_frame = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          state_next = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > CAP) begin
            state_next = ERR;
          end else if (len_full == 16'd0) begin
            state_next = TAIL;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept && word_last) begin
          write_word = 1'b1;
          if (frame_last) begin
            state_next = TAIL;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_next = (bus.in_data == cks_reg) ? DONE : ERR;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg       <= '0;
      byte_cnt_reg  <= '0;
      word_idx_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rst_reg   <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_reg       <= '0;
`endif
    end else begin
      mem_we_reg <= 1'b0;

      if (start_frame) begin
        len_reg      <= '0;
        byte_cnt_reg <= '0;
        word_idx_reg <= '0;
        done_reg     <= 1'b0;
        error_reg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        cks_reg      <= '0;
`endif
      end

      if (accept) begin
        case (state_reg)
          LEN_HI: begin
            len_reg[15:8] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
            cks_reg       <= cks_reg ^ bus.in_data;
`endif
          end
          LEN_LO: begin
            len_reg[7:0] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
            cks_reg      <= cks_reg ^ bus.in_data;
`endif
          end
          DATA: begin
            byte_cnt_reg <= word_last ? '0 : byte_cnt_reg + BCW'(1);
`ifdef LOADER_CHECKSUM_EN
            cks_reg      <= cks_reg ^ bus.in_data;
`endif
          end
          default: begin
          end
        endcase
      end

      // The write strobe lands in the cycle right after the word's last byte.
      if (write_word) begin
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= word_idx_reg[ADDR_WIDTH-1:0];
        mem_wdata_reg <= word_shift;
        word_idx_reg  <= word_idx_reg + 17'd1;
      end

      if (state_next == DONE) begin
        done_reg <= 1'b1;
      end
      if (state_next == ERR) begin
        error_reg <= 1'b1;
      end

      // CPU is released only the cycle after a successful DONE.
      if (state_next inside {LEN_HI, LEN_LO, DATA, CHECK, ERR}) begin
        cpu_rst_reg <= 1'b1;
      end else if (state_reg == DONE) begin
        cpu_rst_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (WORD_WIDTH=16, ADDR_WIDTH=4), table vectors
// plus hand sequences; follows LOADER_CHECKSUM_EN for the frame format.
module tb_program_loader;
  localparam int WW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst;
  logic done;
  logic error;

  program_loader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  program_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          n;
    int          first;
    int          nwords;
    logic        exp_done;
    logic        exp_error;
    logic        exp_cpu_rst;
    bit          gaps;
  } vec_t;

  wr_t         exp_q[$];
  vec_t        vecs[$];
  logic [7:0]  frame_q[$];
  logic [15:0] tbmem [16];
  int tests    = 0;
  int failed   = 0;
  int cyc      = 0;
  int wr_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest pending expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_t e;
      wr_count++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
        check("write_cycle", cyc, e.cyc);
      end
      tbmem[bus.mem_addr] = bus.mem_wdata;
      $display("[TB] write addr=%0d data=%h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends frame_q; payload bytes from index first form nwords expected writes.
  task automatic send_frame(input int first, input int nwords, input bit gaps);
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(frame_q[i]);
      if (i >= first && i < first + 2 * nwords && ((i - first) % 2) == 1) begin
        wr_t e;
        e.addr = 8'((i - first) / 2);
        e.data = {prev, frame_q[i]};
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
      prev = frame_q[i];
    end
  endtask

  function automatic void add_vec(input string nm, input logic [63:0] b, input int n,
                                  input int first, input int nw, input logic d,
                                  input logic e, input logic c, input bit g);
    vec_t v;
    v.name = nm; v.bytes = b; v.n = n; v.first = first; v.nwords = nw;
    v.exp_done = d; v.exp_error = e; v.exp_cpu_rst = c; v.gaps = g;
    vecs.push_back(v);
  endfunction

  task automatic load_basic();
    frame_q.delete();
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(8'h0A);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bb;
    logic [7:0]  cks;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          w0;

`ifdef LOADER_CHECKSUM_EN
    add_vec("basic",        64'hA5_00_02_12_34_56_78_0A, 8, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("bad_cks",      64'hA5_00_02_12_34_56_78_0B, 8, 3, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("recover",      64'hA5_00_01_AB_CD_67_00_00, 6, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("len17",        64'hA5_00_11_12_34_00_00_00, 5, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("garbage_len0", 64'h00_FF_5A_A5_00_00_00_00, 7, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("gaps",         64'hA5_00_02_12_34_56_78_0A, 8, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    add_vec("beef",         64'hA5_00_01_BE_EF_00_00_00, 5, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("idle_extra",   64'h77_00_00_00_00_00_00_00, 1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("len17",        64'hA5_00_11_12_34_00_00_00, 5, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("garbage_len0", 64'h00_FF_5A_A5_00_00_00_00, 6, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("gaps",         64'hA5_00_02_12_34_56_78_00, 7, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values while rst is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);

    // First load: DONE cycle then cpu_rst release one cycle later.
    load_basic();
    w0 = wr_count;
    send_frame(3, 2, 1'b0);
    @(negedge clk);
    check("first_done_cycle_done", 32'(done), 32'd1);
    check("first_done_cycle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("first_done_cycle_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("first_after_done_cpu_rst", 32'(cpu_rst), 32'd0);
    check("first_after_done_in_ready", 32'(bus.in_ready), 32'd1);
    check("first_writes", wr_count - w0, 32'd2);
    check("first_mem0", 32'(tbmem[0]), 32'h1234);
    check("first_mem1", 32'(tbmem[1]), 32'h5678);
    $display("[TB] first frame loaded, done=%0b cpu_rst=%0b", done, cpu_rst);

    foreach (vecs[v]) begin
      frame_q.delete();
      bb = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(bb[63-8*i -: 8]);
      w0 = wr_count;
      send_frame(vecs[v].first, vecs[v].nwords, vecs[v].gaps);
      repeat (3) @(negedge clk);
      check({vecs[v].name, "/writes"}, wr_count - w0, vecs[v].nwords);
      check({vecs[v].name, "/pending"}, 32'(exp_q.size()), 32'd0);
      check({vecs[v].name, "/done"}, 32'(done), 32'(vecs[v].exp_done));
      check({vecs[v].name, "/error"}, 32'(error), 32'(vecs[v].exp_error));
      check({vecs[v].name, "/cpu_rst"}, 32'(cpu_rst), 32'(vecs[v].exp_cpu_rst));
      $display("[TB] vector %s: done=%0b error=%0b cpu_rst=%0b writes=%0d",
               vecs[v].name, done, error, cpu_rst, wr_count - w0);
    end

    // Reset one cycle after payload byte 0x12, then stray bytes, then a clean frame.
    frame_q.delete();
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
    w0 = wr_count;
    send_frame(3, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    rst = 1'b0;
    frame_q.delete();
    frame_q = '{8'h34, 8'h56};
    send_frame(0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("midrst_stray_writes", wr_count - w0, 32'd0);
    check("midrst_stray_done", 32'(done), 32'd0);
    load_basic();
    send_frame(3, 2, 1'b0);
    repeat (3) @(negedge clk);
    check("midrst_reload_writes", wr_count - w0, 32'd2);
    check("midrst_reload_done", 32'(done), 32'd1);
    check("midrst_reload_cpu_rst", 32'(cpu_rst), 32'd0);
    $display("[TB] mid-frame reset and reload: done=%0b writes=%0d", done, wr_count - w0);

    // Full-capacity frame: LEN == 16 fills every address.
    frame_q.delete();
    frame_q = '{8'hA5, 8'h00, 8'h10};
    cks = 8'h10;
    for (int w = 0; w < 16; w++) begin
      hi = 8'(w * 16 + 3);
      lo = 8'(255 - w);
      frame_q.push_back(hi);
      frame_q.push_back(lo);
      cks = cks ^ hi ^ lo;
    end
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(cks);
`endif
    w0 = wr_count;
    send_frame(3, 16, 1'b0);
    repeat (3) @(negedge clk);
    check("cap_writes", wr_count - w0, 32'd16);
    check("cap_done", 32'(done), 32'd1);
    check("cap_error", 32'(error), 32'd0);
    check("cap_mem15", 32'(tbmem[15]), 32'hF3F0);
    $display("[TB] capacity frame: done=%0b writes=%0d", done, wr_count - w0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
